// File: rtl/ddr_app_pkg.sv
// ddr_app_pkg: app-interface command encodings, address shift and backpressure LFSR constants
package ddr_app_pkg;
  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;
  localparam int ADDR_SHIFT = 3;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/ddr_resp_wdf.sv
// ddr_resp_wdf: synchronous FIFO for write beats (data+mask); ports clk, rst_n (async active-low),
// push/din in, pop in, dout out (head, combinational), full/empty flags out
module ddr_resp_wdf #(
  parameter int W = 576,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/ddr_app_resp.sv
// ddr_app_resp: RAM-backed stand-in for the memory controller app interface.
// Ports: ddr_clk/ddr_rst_n (async active-low); app_en/app_cmd/app_addr/app_rdy command channel;
// app_wdf_* write-data channel; app_rd_data/_valid/_end read return; init_calib_complete; sts_proto_err (sticky).
// Build option: DDR_RESP_BP_EN adds LFSR-driven random backpressure on app_rdy and app_wdf_rdy.
module ddr_app_resp
  import ddr_app_pkg::*;
#(
  parameter int DDR_DATA_WD = 512,
  parameter int DDR_ADDR_WD = 32,
  parameter int MEM_AW = 10,
  parameter int RD_LAT = 4,
  parameter int CALIB_CYCLES = 64,
  parameter int WDF_DEPTH = 4
) (
  input  logic                     ddr_clk,
  input  logic                     ddr_rst_n,
  input  logic                     app_en,
  input  logic [2:0]               app_cmd,
  input  logic [DDR_ADDR_WD-1:0]   app_addr,
  output logic                     app_rdy,
  input  logic                     app_wdf_wren,
  input  logic                     app_wdf_end,
  input  logic [DDR_DATA_WD-1:0]   app_wdf_data,
  input  logic [DDR_DATA_WD/8-1:0] app_wdf_mask,
  output logic                     app_wdf_rdy,
  output logic [DDR_DATA_WD-1:0]   app_rd_data,
  output logic                     app_rd_data_valid,
  output logic                     app_rd_data_end,
  output logic                     init_calib_complete,
  output logic                     sts_proto_err
);
  localparam int MW = DDR_DATA_WD / 8;
  localparam int CW = $clog2(CALIB_CYCLES + 1);
  logic calib, pending, rv, bp_cmd, bp_wdf, unused;
  logic [CW-1:0] cnt;
  logic [MEM_AW-1:0] cmd_word, pend_word, c_word;
  logic fifo_full, fifo_empty;
  logic [DDR_DATA_WD-1:0] f_data, c_data, rd_q;
  logic [MW-1:0] f_mask, c_mask;
  logic cmd_acc, wr_acc, rd_acc, bad_acc, beat_acc, beat_direct, push, pop, commit;
  logic [RD_LAT-1:0] vld;
  logic [DDR_DATA_WD-1:0] dpipe [RD_LAT];
  logic [DDR_DATA_WD-1:0] mem [2**MEM_AW];
`ifdef DDR_RESP_BP_EN
  logic [15:0] lfsr;
  always_ff @(posedge ddr_clk or negedge ddr_rst_n)
    if (!ddr_rst_n) lfsr <= LFSR_SEED;
    else lfsr <= lfsr_next(lfsr);
  assign bp_cmd = |lfsr[1:0];
  assign bp_wdf = |lfsr[3:2];
`else
  assign bp_cmd = 1'b1;
  assign bp_wdf = 1'b1;
`endif
  assign unused = ^{app_addr[DDR_ADDR_WD-1:MEM_AW+ADDR_SHIFT], app_addr[ADDR_SHIFT-1:0]};
  assign cmd_word = app_addr[ADDR_SHIFT +: MEM_AW];
  assign app_rdy = calib & ~pending & bp_cmd;
  assign app_wdf_rdy = calib & ~fifo_full & bp_wdf;
  assign cmd_acc = app_en & app_rdy;
  assign wr_acc = cmd_acc & (app_cmd == APP_CMD_WR);
  assign rd_acc = cmd_acc & (app_cmd == APP_CMD_RD);
  assign bad_acc = cmd_acc & ~(app_cmd == APP_CMD_WR) & ~(app_cmd == APP_CMD_RD);
  assign beat_acc = app_wdf_wren & app_wdf_rdy;
  // a beat bypasses the FIFO when a write command is already waiting for it
  assign beat_direct = beat_acc & (pending | (wr_acc & fifo_empty));
  assign push = beat_acc & ~beat_direct;
  assign pop = wr_acc & ~fifo_empty;
  assign commit = pop | beat_direct;
  assign c_word = pending ? pend_word : cmd_word;
  assign c_data = pop ? f_data : app_wdf_data;
  assign c_mask = pop ? f_mask : app_wdf_mask;
  ddr_resp_wdf #(.W(DDR_DATA_WD + MW), .DEPTH(WDF_DEPTH)) u_wdf (
    .clk(ddr_clk),
    .rst_n(ddr_rst_n),
    .push(push),
    .din({app_wdf_mask, app_wdf_data}),
    .pop(pop),
    .dout({f_mask, f_data}),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  always_ff @(posedge ddr_clk or negedge ddr_rst_n)
    if (!ddr_rst_n) begin
      cnt <= '0;
      calib <= 1'b0;
      pending <= 1'b0;
      pend_word <= '0;
      sts_proto_err <= 1'b0;
    end else begin
      if (!calib) begin
        cnt <= cnt + 1'b1;
        if (cnt == CW'(CALIB_CYCLES - 1)) calib <= 1'b1;
      end
      if (wr_acc & fifo_empty & ~beat_acc) begin
        pending <= 1'b1;
        pend_word <= cmd_word;
      end else if (pending & beat_acc) pending <= 1'b0;
      if (bad_acc | (app_wdf_wren ^ app_wdf_end) | (app_wdf_wren & ~app_wdf_rdy)) sts_proto_err <= 1'b1;
    end
  // RAM: nonblocking update makes the read port read-first on a same-edge write
  always_ff @(posedge ddr_clk) begin
    if (rd_acc) rd_q <= mem[cmd_word];
    if (commit)
      for (int b = 0; b < MW; b++)
        if (!c_mask[b]) mem[c_word][b*8 +: 8] <= c_data[b*8 +: 8];
  end
  // rd_q/rv is the RAM output register; the shift below adds RD_LAT more stages
  always_ff @(posedge ddr_clk or negedge ddr_rst_n)
    if (!ddr_rst_n) begin
      rv <= 1'b0;
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) dpipe[i] <= '0;
    end else begin
      rv <= rd_acc;
      vld <= {vld[RD_LAT-2:0], rv};
      dpipe[0] <= rd_q;
      for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
    end
  assign app_rd_data = dpipe[RD_LAT-1];
  assign app_rd_data_valid = vld[RD_LAT-1];
  assign app_rd_data_end = vld[RD_LAT-1];
  assign init_calib_complete = calib;
endmodule

// File: tb/tb_ddr_app_resp.sv
// tb_ddr_app_resp: scoreboard bench for ddr_app_resp (default build, no backpressure)
module tb_ddr_app_resp;
  localparam int DW = 512;
  localparam int AW = 32;
  localparam int MAW = 10;
  localparam int RL = 4;
  localparam int CC = 64;
  localparam int WD = 4;
  logic ddr_clk = 1'b0;
  logic ddr_rst_n = 1'b1;
  logic app_en = 1'b0;
  logic [2:0] app_cmd = 3'b000;
  logic [AW-1:0] app_addr = '0;
  logic app_rdy;
  logic app_wdf_wren = 1'b0;
  logic app_wdf_end = 1'b0;
  logic [DW-1:0] app_wdf_data = '0;
  logic [DW/8-1:0] app_wdf_mask = '0;
  logic app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic app_rd_data_valid, app_rd_data_end, init_calib_complete, sts_proto_err;
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  typedef struct {
    logic [DW-1:0] data;
    int due;
  } exp_t;
  exp_t sb[$];

  ddr_app_resp #(
    .DDR_DATA_WD(DW), .DDR_ADDR_WD(AW), .MEM_AW(MAW),
    .RD_LAT(RL), .CALIB_CYCLES(CC), .WDF_DEPTH(WD)
  ) dut (
    .ddr_clk(ddr_clk),
    .ddr_rst_n(ddr_rst_n),
    .app_en(app_en),
    .app_cmd(app_cmd),
    .app_addr(app_addr),
    .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask),
    .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end),
    .init_calib_complete(init_calib_complete),
    .sts_proto_err(sts_proto_err)
  );

  always #5 ddr_clk = ~ddr_clk;

  // advance one edge, then match any returned read beat against the scoreboard head
  task automatic step();
    exp_t e;
    @(posedge ddr_clk);
    cyc++;
    #1;
    if (app_rd_data_valid) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: valid=1 with no read outstanding at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        if (app_rd_data !== e.data || app_rd_data_end !== 1'b1 || cyc != e.due) begin
          fails++;
          $display("FAIL rd_beat: cycle %0d end=%b data=%h, required cycle %0d end=1 data=%h",
                   cyc, app_rd_data_end, app_rd_data, e.due, e.data);
        end
      end
    end
  endtask

  task automatic idle();
    app_en = 1'b0;
    app_wdf_wren = 1'b0;
    app_wdf_end = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    app_en = 1'b1;
    app_cmd = 3'b001;
    app_addr = addr;
    sb.push_back('{exp, cyc + 1 + RL});
    step();
    idle();
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [DW/8-1:0] m, input bit with_data);
    app_en = 1'b1;
    app_cmd = 3'b000;
    app_addr = addr;
    if (with_data) begin
      app_wdf_wren = 1'b1;
      app_wdf_end = 1'b1;
      app_wdf_data = d;
      app_wdf_mask = m;
    end
    step();
    idle();
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic [DW/8-1:0] m);
    app_wdf_wren = 1'b1;
    app_wdf_end = 1'b1;
    app_wdf_data = d;
    app_wdf_mask = m;
    step();
    idle();
  endtask

  task automatic drain(input string name);
    repeat (RL + 3) step();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_missing: %0d reads outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    #2 ddr_rst_n = 1'b0;
    #1;
    checks++;
    if ({app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete, sts_proto_err} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: rdy=%b wdf_rdy=%b valid=%b end=%b calib=%b err=%b, required all 0",
               app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete, sts_proto_err);
    end
    checks++;
    if (app_rd_data !== '0) begin
      fails++;
      $display("FAIL reset_rd_data: got %h, required 0", app_rd_data);
    end
    repeat (3) step();
  endtask

  task automatic test_calib();
    int early = 0;
    ddr_rst_n = 1'b1;
    repeat (CC - 1) begin
      step();
      if (init_calib_complete | app_rdy | app_wdf_rdy) early++;
    end
    checks++;
    if (early !== 0) begin
      fails++;
      $display("FAIL pre_calib: %0d cycles with calib/rdy/wdf_rdy high, required 0", early);
    end
    step();
    checks++;
    if ({init_calib_complete, app_rdy, app_wdf_rdy} !== 3'b111) begin
      fails++;
      $display("FAIL calib_at_%0d: calib=%b rdy=%b wdf_rdy=%b, required 1 1 1", CC, init_calib_complete, app_rdy, app_wdf_rdy);
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] pat = {64{8'hA5}};
    wr(32'h40, pat, '0, 1);
    rd(32'h40, pat);
    drain("write_read");
  endtask

  task automatic test_cmd_before_data();
    logic [DW-1:0] pat = {16{32'h1234_5678}};
    int early = 0;
    wr(32'h80, '0, '0, 0);
    repeat (4) begin
      if (app_rdy !== 1'b0) early++;
      step();
    end
    if (app_rdy !== 1'b0) early++;
    checks++;
    if (early !== 0) begin
      fails++;
      $display("FAIL pending_rdy: app_rdy high in %0d cycles while write pending, required 0", early);
    end
    beat(pat, '0);
    checks++;
    if (app_rdy !== 1'b1) begin
      fails++;
      $display("FAIL pending_release: app_rdy=%b after data, required 1", app_rdy);
    end
    rd(32'h80, pat);
    drain("cmd_before_data");
  endtask

  task automatic test_fifo_full();
    logic [DW-1:0] d [4];
    int low = 0;
    for (int i = 0; i < 4; i++) d[i] = {16{32'hC0DE_0000 + i}};
    for (int i = 0; i < 4; i++) begin
      if (app_wdf_rdy !== 1'b1) low++;
      beat(d[i], '0);
    end
    checks++;
    if (low !== 0) begin
      fails++;
      $display("FAIL fifo_fill_rdy: wdf_rdy low before %0d of 4 beats, required 0", low);
    end
    checks++;
    if (app_wdf_rdy !== 1'b0) begin
      fails++;
      $display("FAIL fifo_full: wdf_rdy=%b after 4 beats, required 0", app_wdf_rdy);
    end
    wr(32'h0, '0, '0, 0);
    checks++;
    if (app_wdf_rdy !== 1'b1) begin
      fails++;
      $display("FAIL fifo_after_pop: wdf_rdy=%b, required 1", app_wdf_rdy);
    end
    for (int i = 1; i < 4; i++) wr(AW'(i * 8), '0, '0, 0);
    for (int i = 0; i < 4; i++) rd(AW'(i * 8), d[i]);
    drain("fifo_full");
  endtask

  task automatic test_mask_wrap();
    logic [DW-1:0] exp = {{60{8'h00}}, {4{8'hFF}}};
    logic [DW/8-1:0] m = '0;
    m[3:0] = 4'hF;
    wr(32'h0, '1, '0, 1);
    wr(AW'((1 << MAW) << 3), '0, m, 1);
    rd(32'h0, exp);
    drain("mask_wrap");
  endtask

  task automatic test_proto_reset();
    int seen = 0;
    checks++;
    if (sts_proto_err !== 1'b0) begin
      fails++;
      $display("FAIL err_clean: sts_proto_err=%b before errors, required 0", sts_proto_err);
    end
    app_en = 1'b1;
    app_cmd = 3'b111;
    step();
    idle();
    checks++;
    if (sts_proto_err !== 1'b1 || app_rdy !== 1'b1) begin
      fails++;
      $display("FAIL illegal_cmd: err=%b rdy=%b, required err=1 rdy=1", sts_proto_err, app_rdy);
    end
    repeat (3) rd(32'h0, '0);
    ddr_rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({app_rd_data_valid, sts_proto_err, init_calib_complete, app_rdy} !== 4'b0) begin
      fails++;
      $display("FAIL reset_mid: valid=%b err=%b calib=%b rdy=%b, required all 0",
               app_rd_data_valid, sts_proto_err, init_calib_complete, app_rdy);
    end
    repeat (2) step();
    ddr_rst_n = 1'b1;
    repeat (RL + 4) begin
      step();
      if (app_rd_data_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL reset_flush: %0d read beats after reset, required 0", seen);
    end
    app_wdf_wren = 1'b1;
    app_wdf_end = 1'b1;
    step();
    idle();
    checks++;
    if (sts_proto_err !== 1'b1) begin
      fails++;
      $display("FAIL beat_not_ready: err=%b after beat with wdf_rdy low, required 1", sts_proto_err);
    end
    ddr_rst_n = 1'b0;
    step();
    ddr_rst_n = 1'b1;
    checks++;
    if (sts_proto_err !== 1'b0) begin
      fails++;
      $display("FAIL err_reset: err=%b after reset, required 0", sts_proto_err);
    end
    repeat (CC) step();
    checks++;
    if (init_calib_complete !== 1'b1) begin
      fails++;
      $display("FAIL recalib: calib=%b %0d cycles after reset, required 1", init_calib_complete, CC);
    end
    app_wdf_wren = 1'b1;
    app_wdf_end = 1'b0;
    step();
    idle();
    checks++;
    if (sts_proto_err !== 1'b1) begin
      fails++;
      $display("FAIL wren_end: err=%b after wren!=end, required 1", sts_proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_calib();
    test_write_read();
    test_cmd_before_data();
    test_fifo_full();
    test_mask_wrap();
    test_proto_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
